// File: rtl/cpu_mode_loader.sv
// Front-panel sequencer: synchronizes the mode switch and step key, loads/reads
// memory bytes in IN/CHECK modes, and releases the CPU from reset in RUN mode.
module cpu_mode_loader #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode_req,
    input  logic              key,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        cpustate,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_IN   = 2'b01;
    localparam logic [1:0] M_CHK  = 2'b10;
    localparam logic [1:0] M_RUN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN_WAIT,
        S_IN_WR,
        S_CHK_RD,
        S_CHK_LAT,
        S_CHK_WAIT,
        S_RUN
    } state_e;

    logic [1:0]        mode_meta_q, mode_s_q;
    logic              key_meta_q, key_s_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              key_evt_q;
    logic              mode_chg_c;

    state_e            state_q;
    logic [1:0]        cpustate_q;
    logic              cpu_rst_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, re_q;
    logic [DATA_W-1:0] disp_q;
    logic              busy_q;

    // Input synchronizers and key debounce; key_evt fires once as the count saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_meta_q <= M_IDLE;
            mode_s_q    <= M_IDLE;
            key_meta_q  <= 1'b0;
            key_s_q     <= 1'b0;
            cnt_q       <= '0;
            key_evt_q   <= 1'b0;
        end else begin
            mode_meta_q <= mode_req;
            mode_s_q    <= mode_meta_q;
            key_meta_q  <= key;
            key_s_q     <= key_meta_q;
            if (!key_s_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(DEBOUNCE)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            key_evt_q <= key_s_q && (cnt_q == CNT_W'(DEBOUNCE - 1));
        end
    end

    assign mode_chg_c = (mode_s_q != cpustate_q);

    // Loader FSM; every mode change passes through one IDLE cycle with cpustate=00
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cpustate_q <= M_IDLE;
            cpu_rst_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            disp_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            busy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cpustate_q <= mode_s_q;
                    cpu_rst_q  <= (mode_s_q == M_RUN);
                    case (mode_s_q)
                        M_IN: begin
                            state_q <= S_IN_WAIT;
                            addr_q  <= '0;
                        end
                        M_CHK: begin
                            state_q <= S_CHK_RD;
                            addr_q  <= '0;
                            re_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                        M_RUN:   state_q <= S_RUN;
                        default: state_q <= S_IDLE;
                    endcase
                end
                S_IN_WAIT: begin
                    if (mode_chg_c) begin
                        state_q    <= S_IDLE;
                        cpustate_q <= M_IDLE;
                        cpu_rst_q  <= 1'b0;
                    end else if (key_evt_q) begin
                        state_q <= S_IN_WR;
                        wdata_q <= sw_data;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                // Pending mode changes are honoured only once the access has finished
                S_IN_WR: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (mode_chg_c) begin
                        state_q    <= S_IDLE;
                        cpustate_q <= M_IDLE;
                        cpu_rst_q  <= 1'b0;
                    end else begin
                        state_q <= S_IN_WAIT;
                    end
                end
                S_CHK_RD: begin
                    state_q <= S_CHK_LAT;
                    busy_q  <= 1'b1;
                end
                S_CHK_LAT: begin
                    disp_q <= mem_rdata;
                    if (mode_chg_c) begin
                        state_q    <= S_IDLE;
                        cpustate_q <= M_IDLE;
                        cpu_rst_q  <= 1'b0;
                    end else begin
                        state_q <= S_CHK_WAIT;
                    end
                end
                S_CHK_WAIT: begin
                    if (mode_chg_c) begin
                        state_q    <= S_IDLE;
                        cpustate_q <= M_IDLE;
                        cpu_rst_q  <= 1'b0;
                    end else if (key_evt_q) begin
                        state_q <= S_CHK_RD;
                        addr_q  <= addr_q + ADDR_W'(1);
                        re_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (mode_chg_c) begin
                        state_q    <= S_IDLE;
                        cpustate_q <= M_IDLE;
                        cpu_rst_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    cpustate_q <= M_IDLE;
                    cpu_rst_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpustate  = cpustate_q;
    assign cpu_rst   = cpu_rst_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign disp_data = disp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Directed bench for cpu_mode_loader with a small behavioural memory.
module tb_cpu_mode_loader;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode_req;
    logic              key;
    logic [DATA_W-1:0] sw_data;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        cpustate;
    logic              cpu_rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] disp_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mode_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE(4)) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .key(key),
        .sw_data(sw_data), .mem_rdata(mem_rdata), .cpustate(cpustate),
        .cpu_rst(cpu_rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .disp_data(disp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: write on mem_we, read data valid the cycle after mem_re
    logic [DATA_W-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int we_cnt = 0;
    int re_cnt = 0;
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (busy)   busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        logic [7:0] sw;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
    } in_vec_t;

    typedef struct {
        logic [3:0] exp_addr;
        logic [7:0] exp_disp;
    } chk_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpustate"},  32'(cpustate),  32'd0);
        chk({tag, "_cpu_rst"},   32'(cpu_rst),   32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_re"},    32'(mem_re),    32'd0);
        chk({tag, "_disp_data"}, 32'(disp_data), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Raise the key and wait (bounded) for the resulting write or read strobe
    task automatic press_wait(input logic [7:0] d, input bit want_re, output int lat);
        sw_data = d;
        key = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((want_re ? mem_re : mem_we) == 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_key(input int hold);
        repeat (hold) @(negedge clk);
        key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_vec_t  in_tab [3];
        chk_vec_t chk_tab [2];
        int lat;
        int b0, w0, r0, viol;

        in_tab[0] = '{sw: 8'h10, exp_addr: 4'd0, exp_data: 8'h10};
        in_tab[1] = '{sw: 8'h20, exp_addr: 4'd1, exp_data: 8'h20};
        in_tab[2] = '{sw: 8'h30, exp_addr: 4'd2, exp_data: 8'h30};
        chk_tab[0] = '{exp_addr: 4'd1, exp_disp: 8'h20};
        chk_tab[1] = '{exp_addr: 4'd2, exp_disp: 8'h30};

        reset = 1'b0; mode_req = 2'b00; key = 1'b0; sw_data = '0;
        wait_cycles(3);
        chk_reset_vals("reset");
        reset = 1'b1;
        wait_cycles(2);

        // Enter IN: synchronizer (2) plus IDLE commit (1)
        mode_req = 2'b01;
        wait_cycles(2);
        chk("in_entry_early", 32'(cpustate), 32'd0);
        wait_cycles(1);
        chk("in_entry", 32'(cpustate), 32'd1);

        b0 = busy_cnt;
        for (int i = 0; i < 3; i++) begin
            press_wait(in_tab[i].sw, 1'b0, lat);
            chk("in_latency", 32'(lat), 32'd7);
            chk("in_addr", 32'(mem_addr), 32'(in_tab[i].exp_addr));
            chk("in_data", 32'(mem_wdata), 32'(in_tab[i].exp_data));
            chk("in_busy", 32'(busy), 32'd1);
            chk("in_cpustate", 32'(cpustate), 32'd1);
            wait_cycles(1);
            chk("in_we_one_cycle", 32'(mem_we), 32'd0);
            chk("in_busy_drop", 32'(busy), 32'd0);
            release_key(3);
            chk("in_we_count", 32'(we_cnt), 32'(i + 1));
        end
        chk("in_busy_cycles", 32'(busy_cnt - b0), 32'd3);

        // Bounce: 2 high, 1 low, 3 high, 2 low, then held 10 cycles
        sw_data = 8'h44;
        key = 1'b1; wait_cycles(2);
        key = 1'b0; wait_cycles(1);
        key = 1'b1; wait_cycles(3);
        key = 1'b0; wait_cycles(2);
        chk("bounce_no_write", 32'(we_cnt), 32'd3);
        key = 1'b1; wait_cycles(10);
        key = 1'b0; wait_cycles(4);
        chk("bounce_one_write", 32'(we_cnt), 32'd4);
        chk("bounce_ptr", 32'(mem_addr), 32'd4);

        // CHECK mode entry through one IDLE cycle
        mode_req = 2'b10;
        wait_cycles(2);
        chk("chk_pre_cpustate", 32'(cpustate), 32'd1);
        wait_cycles(1);
        chk("chk_idle_cpustate", 32'(cpustate), 32'd0);
        wait_cycles(1);
        chk("chk_cpustate", 32'(cpustate), 32'd2);
        chk("chk_re", 32'(mem_re), 32'd1);
        chk("chk_addr0", 32'(mem_addr), 32'd0);
        chk("chk_busy_rd", 32'(busy), 32'd1);
        wait_cycles(1);
        chk("chk_re_drop", 32'(mem_re), 32'd0);
        chk("chk_busy_lat", 32'(busy), 32'd1);
        wait_cycles(1);
        chk("chk_disp0", 32'(disp_data), 32'h10);
        chk("chk_busy_wait", 32'(busy), 32'd0);

        for (int i = 0; i < 2; i++) begin
            press_wait(8'h00, 1'b1, lat);
            chk("chk_latency", 32'(lat), 32'd7);
            chk("chk_addr", 32'(mem_addr), 32'(chk_tab[i].exp_addr));
            wait_cycles(2);
            chk("chk_disp", 32'(disp_data), 32'(chk_tab[i].exp_disp));
            release_key(3);
        end

        // RUN: 4 cycles from change, no memory strobes, key ignored
        mode_req = 2'b11;
        wait_cycles(3);
        chk("run_idle_cpustate", 32'(cpustate), 32'd0);
        chk("run_idle_cpu_rst", 32'(cpu_rst), 32'd0);
        wait_cycles(1);
        chk("run_cpustate", 32'(cpustate), 32'd3);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd1);
        w0 = we_cnt; r0 = re_cnt; viol = 0;
        key = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_we || mem_re || !cpu_rst || mem_addr != 4'd2) viol++;
        end
        key = 1'b0;
        wait_cycles(4);
        chk("run_violations", 32'(viol), 32'd0);
        chk("run_no_strobes", 32'((we_cnt - w0) + (re_cnt - r0)), 32'd0);

        mode_req = 2'b00;
        wait_cycles(2);
        chk("run_exit_hold", 32'(cpu_rst), 32'd1);
        wait_cycles(1);
        chk("run_exit_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_exit_cpustate", 32'(cpustate), 32'd0);
        wait_cycles(1);
        chk("idle_stays", 32'(cpustate), 32'd0);

        // Mode change arriving during IN_WR is deferred until the write ends
        mode_req = 2'b01;
        wait_cycles(3);
        chk("in2_entry", 32'(cpustate), 32'd1);
        sw_data = 8'h55;
        key = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 5) mode_req = 2'b10;
        end
        chk("defer_we", 32'(mem_we), 32'd1);
        chk("defer_addr", 32'(mem_addr), 32'd0);
        chk("defer_cpustate", 32'(cpustate), 32'd1);
        wait_cycles(1);
        chk("defer_we_drop", 32'(mem_we), 32'd0);
        chk("defer_idle", 32'(cpustate), 32'd0);
        wait_cycles(1);
        chk("defer_new_mode", 32'(cpustate), 32'd2);
        chk("defer_re", 32'(mem_re), 32'd1);
        chk("defer_re_addr", 32'(mem_addr), 32'd0);
        wait_cycles(2);
        chk("defer_disp", 32'(disp_data), 32'h55);
        key = 1'b0;
        wait_cycles(4);

        // Pointer wrap: 17 writes, the 17th lands back at address 0
        mode_req = 2'b01;
        wait_cycles(4);
        chk("wrap_entry", 32'(cpustate), 32'd1);
        for (int i = 0; i < 17; i++) begin
            press_wait(8'(8'h80 + i), 1'b0, lat);
            chk("wrap_addr", 32'(mem_addr), 32'(i % 16));
            chk("wrap_data", 32'(mem_wdata), 32'(8'h80 + i));
            release_key(1);
        end

        // Asynchronous reset in the middle of a write
        w0 = we_cnt;
        press_wait(8'h77, 1'b0, lat);
        chk("abort_we_seen", 32'(mem_we), 32'd1);
        chk("abort_addr", 32'(mem_addr), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        key = 1'b0;
        reset = 1'b1;
        chk("abort_single_we", 32'(we_cnt - w0), 32'd1);
        wait_cycles(2);
        chk("restart_pre", 32'(cpustate), 32'd0);
        wait_cycles(1);
        chk("restart_cpustate", 32'(cpustate), 32'd1);
        press_wait(8'h99, 1'b0, lat);
        chk("restart_latency", 32'(lat), 32'd7);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_data", 32'(mem_wdata), 32'h99);
        release_key(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
